tl_ul_arbiter2: RTL and testbench

Two-to-one TileLink-UL/UH port arbiter that shares one downstream A/D buffer pair (the 32-bit-data, 7-bit-source A/D queue wrapper) between two upstream requesters. A requests are merged with requester-tagged source IDs; D responses are routed back by tag. Sits directly upstream of the buffer pair in the tile's memory-port path.

---
 rtl/tl_ul_arb_pkg.sv | 32 +++
 rtl/tl_ul_arbiter2_if.sv | 46 ++++
 rtl/tl_beat_counter.sv | 31 +++
 rtl/tl_ul_arbiter2.sv | 147 ++++++++++++++
 tb/tb_tl_ul_arbiter2.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_ul_arb_pkg.sv
// tl_ul_arbiter2 shared definitions: TL-UL field widths,
// opcodes and the beats-per-message helper.
package tl_ul_arb_pkg;

  localparam int A_W   = 82;
  localparam int AM_W  = 83;
  localparam int D_W   = 50;
  localparam int DR_W  = 49;
  localparam int SRC_W = 6;

  localparam logic [2:0] OP_PUT_FULL          = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL       = 3'd1;
  localparam logic [2:0] OP_ARITH             = 3'd2;
  localparam logic [2:0] OP_LOGICAL           = 3'd3;
  localparam logic [2:0] OP_GET               = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK_DATA   = 3'd1;

  typedef logic [4:0] beats_t;

  // 4-byte beats; messages wider than 64 bytes clamp to 16
  function automatic beats_t tl_beats(
    input logic       has_data,
    input logic [3:0] size
  );
    beats_t n;
    if (!has_data || size <= 4'd2) n = 5'd1;
    else if (size >= 4'd6)         n = 5'd16;
    else                           n = 5'd1 << (size - 4'd2);
    return n;
  endfunction

endpackage

// File: rtl/tl_ul_arbiter2_if.sv
// tl_ul_arbiter2 bus bundle: two upstream A/D ports
// and the merged downstream A/D port.
interface tl_ul_arbiter2_if;
  import tl_ul_arb_pkg::*;

  logic            a0_valid;
  logic            a0_ready;
  logic [A_W-1:0]  a0_bits;
  logic            a1_valid;
  logic            a1_ready;
  logic [A_W-1:0]  a1_bits;

  logic            a_valid;
  logic            a_ready;
  logic [AM_W-1:0] a_bits;

  logic            d_valid;
  logic            d_ready;
  logic [D_W-1:0]  d_bits;

  logic            d0_valid;
  logic            d0_ready;
  logic [DR_W-1:0] d0_bits;
  logic            d1_valid;
  logic            d1_ready;
  logic [DR_W-1:0] d1_bits;

  modport master (
    input  a0_valid, a0_bits, a1_valid, a1_bits,
    input  a_ready, d_valid, d_bits,
    input  d0_ready, d1_ready,
    output a0_ready, a1_ready, a_valid, a_bits,
    output d_ready, d0_valid, d0_bits,
    output d1_valid, d1_bits
  );

  modport slave (
    output a0_valid, a0_bits, a1_valid, a1_bits,
    output a_ready, d_valid, d_bits,
    output d0_ready, d1_ready,
    input  a0_ready, a1_ready, a_valid, a_bits,
    input  d_ready, d0_valid, d0_bits,
    input  d1_valid, d1_bits
  );

endinterface

// File: rtl/tl_beat_counter.sv
// Remaining-beat counter for one multi-beat message:
// load with beats-1 on the first beat, count down after.
module tl_beat_counter
  import tl_ul_arb_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   load,
  input  beats_t load_val,
  input  logic   dec,
  output logic   busy,
  output logic   last
);

  beats_t cnt_q;

  // load on first beat, decrement on each later beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == 5'd1);

endmodule

// File: rtl/tl_ul_arbiter2.sv
// Two-to-one TL-UL arbiter with tagged sources and D routing.
// TL_ARB_RR_EN selects round-robin; otherwise port 0 has priority.
module tl_ul_arbiter2
  import tl_ul_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 15
) (
  input logic             clock,
  input logic             reset_n,
  tl_ul_arbiter2_if.master bus
);

  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]     state;
  logic           gnt_q;
  logic           stall_q;
  logic [3:0]     out0_q;
  logic [3:0]     out1_q;
  logic           elig0;
  logic           elig1;
  logic           pick;
  logic           hold;
  logic           sel;
  logic           req;
  logic [A_W-1:0] a_sel;
  beats_t         a_beats;
  logic           a_fire;
  logic           first;
  logic           a_last;
  logic           a_busy;
  logic           a_cnt_last;
  logic           tgt;
  logic           d_fire;
  beats_t         d_beats;
  logic           d_busy;
  logic           d_cnt_last;
  logic           d_last;
  logic           inc0;
  logic           inc1;
  logic           dec0;
  logic           dec1;

  assign state = a_busy ? LOCKED : IDLE;
  assign elig0 = bus.a0_valid && (out0_q < MAX_O);
  assign elig1 = bus.a1_valid && (out1_q < MAX_O);

`ifdef TL_ARB_RR_EN
  logic ptr_q;
  assign pick = elig1 & (~elig0 | ptr_q);
`else
  assign pick = ~elig0 & elig1;
`endif

  assign hold  = (state == LOCKED) | stall_q;
  assign sel   = hold ? gnt_q : pick;
  assign req   = hold ? (sel ? bus.a1_valid : bus.a0_valid)
                      : (elig0 | elig1);
  assign a_sel = sel ? bus.a1_bits : bus.a0_bits;

  assign bus.a_valid  = reset_n & req;
  assign bus.a0_ready = reset_n & req & ~sel & bus.a_ready;
  assign bus.a1_ready = reset_n & req & sel & bus.a_ready;
  assign bus.a_bits   = {a_sel[81:72], sel, a_sel[71:0]};

  assign a_fire  = bus.a_valid & bus.a_ready;
  assign first   = (state == IDLE);
  assign a_beats = tl_beats(a_sel[81:79] < OP_GET, a_sel[75:72]);
  assign a_last  = first ? (a_beats == 5'd1) : a_cnt_last;

  tl_beat_counter u_a_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (a_fire & first),
    .load_val (a_beats - 5'd1),
    .dec      (a_fire & ~first),
    .busy     (a_busy),
    .last     (a_cnt_last)
  );

  // remember the grant and whether the head beat is stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      gnt_q   <= sel;
      stall_q <= bus.a_valid & ~bus.a_ready;
    end
  end

`ifdef TL_ARB_RR_EN
  // after a message completes, favour the other requester
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (a_fire && a_last) begin
      ptr_q <= ~sel;
    end
  end
`endif

  assign tgt          = bus.d_bits[40];
  assign bus.d_ready  = reset_n & (tgt ? bus.d1_ready
                                       : bus.d0_ready);
  assign bus.d0_valid = reset_n & bus.d_valid & ~tgt;
  assign bus.d1_valid = reset_n & bus.d_valid & tgt;
  assign bus.d0_bits  = {bus.d_bits[49:41], bus.d_bits[39:0]};
  assign bus.d1_bits  = {bus.d_bits[49:41], bus.d_bits[39:0]};

  assign d_fire  = bus.d_valid & bus.d_ready;
  assign d_beats = tl_beats(
    bus.d_bits[49:47] == OP_ACCESS_ACK_DATA,
    bus.d_bits[44:41]);
  assign d_last  = d_busy ? d_cnt_last : (d_beats == 5'd1);

  tl_beat_counter u_d_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (d_fire & ~d_busy),
    .load_val (d_beats - 5'd1),
    .dec      (d_fire & d_busy),
    .busy     (d_busy),
    .last     (d_cnt_last)
  );

  assign inc0 = a_fire & first & ~sel;
  assign inc1 = a_fire & first & sel;
  assign dec0 = d_fire & d_last & ~tgt & (out0_q != 4'd0);
  assign dec1 = d_fire & d_last & tgt & (out1_q != 4'd0);

  // in-flight message count per requester
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out0_q <= 4'd0;
      out1_q <= 4'd0;
    end else begin
      if (inc0 && !dec0)      out0_q <= out0_q + 4'd1;
      else if (dec0 && !inc0) out0_q <= out0_q - 4'd1;
      if (inc1 && !dec1)      out1_q <= out1_q + 4'd1;
      else if (dec1 && !inc1) out1_q <= out1_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_tl_ul_arbiter2.sv
// Directed testbench for tl_ul_arbiter2 (MAX_OUTSTANDING=2).
// Expectations follow TL_ARB_RR_EN when it is defined.
module tb_tl_ul_arbiter2;
  import tl_ul_arb_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  tl_ul_arbiter2_if bus ();

  tl_ul_arbiter2 #(.MAX_OUTSTANDING(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [A_W-1:0] mk_a(
    input logic [2:0] op, input logic [3:0] size,
    input logic [5:0] src, input logic [31:0] data);
    return {op, 3'b0, size, src, 30'h0, 4'hF, data};
  endfunction

  function automatic logic [AM_W-1:0] mk_am(
    input logic [2:0] op, input logic [3:0] size,
    input logic [6:0] src, input logic [31:0] data);
    return {op, 3'b0, size, src, 30'h0, 4'hF, data};
  endfunction

  function automatic logic [D_W-1:0] mk_d(
    input logic [2:0] op, input logic [3:0] size,
    input logic [6:0] src, input logic [31:0] data);
    return {op, 2'b0, size, src, 1'b0, data, 1'b0};
  endfunction

  function automatic logic [DR_W-1:0] mk_dr(
    input logic [2:0] op, input logic [3:0] size,
    input logic [5:0] src, input logic [31:0] data);
    return {op, 2'b0, size, src, 1'b0, data, 1'b0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a0_valid = 0;
    bus.a1_valid = 0;
    bus.a0_bits  = '0;
    bus.a1_bits  = '0;
    bus.a_ready  = 0;
    bus.d_valid  = 0;
    bus.d_bits   = '0;
    bus.d0_ready = 0;
    bus.d1_ready = 0;
  endtask

  task automatic test_reset();
    logic [5:0] hs;
    bus.a0_valid = 1;
    bus.a1_valid = 1;
    bus.a0_bits  = mk_a(4, 2, 6'h01, 0);
    bus.a1_bits  = mk_a(4, 2, 6'h02, 0);
    bus.a_ready  = 1;
    bus.d_valid  = 1;
    bus.d_bits   = mk_d(1, 3, 7'h45, 0);
    bus.d0_ready = 1;
    bus.d1_ready = 1;
    #2;
    hs = {bus.a_valid, bus.a0_ready, bus.a1_ready,
          bus.d_ready, bus.d0_valid, bus.d1_valid};
    checks++;
    if (hs !== 6'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b want 000000", hs);
    end
    idle_inputs();
    step();
    reset_n = 1;
    step();
    checks++;
    if (bus.a_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: a_valid=%b want 0",
               bus.a_valid);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] gseq;
    logic       g;
    logic [6:0] es;
`ifdef TL_ARB_RR_EN
    gseq = 4'b1010;
`else
    gseq = 4'b1100;
`endif
    bus.a0_bits  = mk_a(4, 2, 6'h05, 0);
    bus.a1_bits  = mk_a(4, 2, 6'h0A, 0);
    bus.a0_valid = 1;
    bus.a1_valid = 1;
    bus.a_ready  = 1;
    for (int i = 0; i < 4; i++) begin
      g  = gseq[i];
      es = g ? 7'h4A : 7'h05;
      #1;
      checks++;
      if (bus.a_bits !== mk_am(4, 2, es, 0)) begin
        errors++;
        $display("FAIL arb_bits[%0d]: got %h want %h",
                 i, bus.a_bits, mk_am(4, 2, es, 0));
      end
      checks++;
      if (bus.a0_ready !== ~g || bus.a1_ready !== g) begin
        errors++;
        $display("FAIL arb_ready[%0d]: got %b%b want %b%b",
                 i, bus.a0_ready, bus.a1_ready, ~g, g);
      end
      step();
    end
    #1;
    checks++;
    if (bus.a_valid !== 1'b0) begin
      errors++;
      $display("FAIL arb_limit: a_valid=%b want 0",
               bus.a_valid);
    end
    bus.a0_valid = 0;
    bus.a1_valid = 0;
    bus.d0_ready = 1;
    bus.d1_ready = 1;
    bus.d_valid  = 1;
    for (int i = 0; i < 4; i++) begin
      g = (i >= 2);
      bus.d_bits = mk_d(0, 2, g ? 7'h4A : 7'h05, 0);
      #1;
      checks++;
      if ({bus.d0_valid, bus.d1_valid, bus.d_ready}
          !== {~g, g, 1'b1}) begin
        errors++;
        $display("FAIL d_route[%0d]: got %b%b%b want %b%b1",
                 i, bus.d0_valid, bus.d1_valid,
                 bus.d_ready, ~g, g);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_burst();
    bus.a_ready  = 1;
    bus.a1_valid = 1;
    bus.a0_bits  = mk_a(4, 2, 6'h01, 0);
    for (int i = 0; i < 4; i++) begin
      bus.a0_valid = (i >= 1);
      bus.a1_bits  = mk_a(0, 4, 6'h02, 32'hB0 + i);
      #1;
      checks++;
      if (bus.a_bits !== mk_am(0, 4, 7'h42, 32'hB0 + i)) begin
        errors++;
        $display("FAIL burst_bits[%0d]: got %h", i, bus.a_bits);
      end
      checks++;
      if (bus.a0_ready !== 1'b0 || bus.a1_ready !== 1'b1) begin
        errors++;
        $display("FAIL burst_ready[%0d]: got %b%b want 01",
                 i, bus.a0_ready, bus.a1_ready);
      end
      step();
    end
    bus.a1_valid = 0;
    #1;
    checks++;
    if (bus.a0_ready !== 1'b1 ||
        bus.a_bits !== mk_am(4, 2, 7'h01, 0)) begin
      errors++;
      $display("FAIL burst_next: a0_ready=%b bits=%h want 1",
               bus.a0_ready, bus.a_bits);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [7:0]  pat;
    logic [31:0] beat;
    pat  = 8'b1101_0100;
    beat = 0;
    bus.a0_valid = 1;
    bus.a1_bits  = mk_a(4, 2, 6'h03, 0);
    for (int i = 0; i < 8; i++) begin
      bus.a_ready  = pat[i];
      bus.a1_valid = (i >= 1);
      bus.a0_bits  = mk_a(0, 4, 6'h04, 32'hC0 + beat);
      #1;
      checks++;
      if (bus.a_bits !== mk_am(0, 4, 7'h04, 32'hC0 + beat)) begin
        errors++;
        $display("FAIL stall_bits[%0d]: got %h", i, bus.a_bits);
      end
      checks++;
      if (bus.a0_ready !== pat[i] || bus.a1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b%b want %b0",
                 i, bus.a0_ready, bus.a1_ready, pat[i]);
      end
      step();
      if (pat[i]) beat++;
    end
    bus.a0_valid = 0;
    bus.a_ready  = 1;
    #1;
    checks++;
    if (bus.a1_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: a1_ready=%b want 1",
               bus.a1_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_outstanding();
    bus.a0_valid = 1;
    bus.a0_bits  = mk_a(4, 2, 6'h05, 0);
    bus.a_ready  = 1;
    #1;
    checks++;
    if (bus.a0_ready !== 1'b0 || bus.a_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_full: a0_ready=%b a_valid=%b want 00",
               bus.a0_ready, bus.a_valid);
    end
    bus.d_valid  = 1;
    bus.d_bits   = mk_d(0, 2, 7'h05, 0);
    bus.d0_ready = 1;
    #1;
    checks++;
    if (bus.d0_valid !== 1'b1 || bus.d_ready !== 1'b1 ||
        bus.d0_bits !== mk_dr(0, 2, 6'h05, 0)) begin
      errors++;
      $display("FAIL out_dresp: d0_valid=%b d_ready=%b want 11",
               bus.d0_valid, bus.d_ready);
    end
    step();
    bus.d_valid = 0;
    #1;
    checks++;
    if (bus.a0_ready !== 1'b1) begin
      errors++;
      $display("FAIL out_free: a0_ready=%b want 1", bus.a0_ready);
    end
    bus.a0_valid = 0;
    step();
    idle_inputs();
  endtask

  task automatic test_d_multi();
    bus.d_valid  = 1;
    bus.d0_ready = 1;
    bus.d1_ready = 0;
    bus.d_bits   = mk_d(1, 3, 7'h45, 32'hD0);
    #1;
    checks++;
    if ({bus.d1_valid, bus.d0_valid, bus.d_ready}
        !== 3'b100) begin
      errors++;
      $display("FAIL dm_bp: got %b%b%b want 100",
               bus.d1_valid, bus.d0_valid, bus.d_ready);
    end
    step();
    bus.d1_ready = 1;
    for (int i = 0; i < 2; i++) begin
      bus.d_bits = mk_d(1, 3, 7'h45, 32'hD0 + i);
      #1;
      checks++;
      if (bus.d_ready !== 1'b1 || bus.d0_valid !== 1'b0 ||
          bus.d1_bits !== mk_dr(1, 3, 6'h05, 32'hD0 + i)) begin
        errors++;
        $display("FAIL dm_beat[%0d]: rdy=%b d0v=%b bits=%h",
                 i, bus.d_ready, bus.d0_valid, bus.d1_bits);
      end
      step();
    end
    bus.d_valid  = 0;
    bus.a1_valid = 1;
    bus.a1_bits  = mk_a(4, 2, 6'h06, 0);
    bus.a_ready  = 1;
    #1;
    checks++;
    if (bus.a1_ready !== 1'b1) begin
      errors++;
      $display("FAIL dm_cnt1: a1_ready=%b want 1", bus.a1_ready);
    end
    step();
    checks++;
    if (bus.a1_ready !== 1'b0) begin
      errors++;
      $display("FAIL dm_cnt2: a1_ready=%b want 0", bus.a1_ready);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    logic [5:0] hs;
    bus.a_ready  = 1;
    bus.d0_ready = 1;
    bus.d1_ready = 1;
    bus.d_valid  = 1;
    bus.d_bits   = mk_d(0, 2, 7'h05, 0);
    bus.a0_valid = 1;
    bus.a0_bits  = mk_a(4, 2, 6'h07, 0);
    #1;
    checks++;
    if (bus.a0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_same: a0_ready=%b want 1", bus.a0_ready);
    end
    step();
    bus.d_valid = 0;
    for (int i = 0; i < 2; i++) begin
      bus.a0_bits = mk_a(0, 4, 6'h08, 32'hE0 + i);
      #1;
      checks++;
      if (bus.a0_ready !== 1'b1) begin
        errors++;
        $display("FAIL rm_beat[%0d]: a0_ready=%b want 1",
                 i, bus.a0_ready);
      end
      step();
    end
    bus.a0_bits = mk_a(0, 4, 6'h08, 32'hE2);
    bus.a1_valid = 1;
    bus.d_valid  = 1;
    bus.d_bits   = mk_d(1, 3, 7'h45, 0);
    reset_n = 0;
    #1;
    hs = {bus.a_valid, bus.a0_ready, bus.a1_ready,
          bus.d_ready, bus.d0_valid, bus.d1_valid};
    checks++;
    if (hs !== 6'b0) begin
      errors++;
      $display("FAIL rm_forced: got %b want 000000", hs);
    end
    step();
    idle_inputs();
    reset_n = 1;
    step();
    bus.a_ready  = 1;
    bus.a0_valid = 1;
    bus.a1_valid = 1;
    bus.a0_bits  = mk_a(4, 2, 6'h01, 0);
    bus.a1_bits  = mk_a(4, 2, 6'h02, 0);
    #1;
    checks++;
    if (bus.a_bits !== mk_am(4, 2, 7'h01, 0) ||
        bus.a1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_ptr: bits=%h a1_ready=%b want src 01",
               bus.a_bits, bus.a1_ready);
    end
    step();
    bus.a1_valid = 0;
    #1;
    checks++;
    if (bus.a0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_cnt1: a0_ready=%b want 1", bus.a0_ready);
    end
    step();
    checks++;
    if (bus.a0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_cnt2: a0_ready=%b want 0", bus.a0_ready);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_d_saturate();
    bus.d_valid  = 1;
    bus.d1_ready = 1;
    bus.d_bits   = mk_d(0, 2, 7'h41, 0);
    #1;
    checks++;
    if (bus.d1_valid !== 1'b1 || bus.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_route: d1_valid=%b d_ready=%b want 11",
               bus.d1_valid, bus.d_ready);
    end
    step();
    bus.d_valid  = 0;
    bus.a_ready  = 1;
    bus.a1_valid = 1;
    bus.a1_bits  = mk_a(4, 2, 6'h09, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.a1_ready !== (i < 2)) begin
        errors++;
        $display("FAIL sat_cnt[%0d]: a1_ready=%b want %b",
                 i, bus.a1_ready, (i < 2));
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeds bound", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    clock   = 0;
    reset_n = 0;
    idle_inputs();
    test_reset();
    test_arbitration();
    test_burst();
    test_stall();
    test_outstanding();
    test_d_multi();
    test_reset_mid();
    test_d_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
